// File: rtl/mul_div_unit_mod.sv
// Iterative unsigned multiply/divide unit with a start/busy/done handshake and a one-cycle write-back request.
// Optional feature: define MULDIV_FAST_ZERO_EN to finish zero-operand ops without iterating.
module mul_div_unit_mod #(
  parameter int DATA_W = 34,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              write_en_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // CALC  | iterating, one bit per cycle, then one cycle to publish the result
  // DONE  | result_o valid, write-back request asserted for one cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] opd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic              accept;
  logic              fast_zero;
  logic [DATA_W-1:0] fast_result;

  // hi_q holds the product high word / partial remainder; lo_q the multiplier / dividend-quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {hi_q, lo_q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, opd_q});
  end

  assign accept = start_i && (state == IDLE);

`ifdef MULDIV_FAST_ZERO_EN
  always_comb begin
    fast_zero   = op_i[1] ? (operand_b_i == '0)
                          : ((operand_a_i == '0) || (operand_b_i == '0));
    fast_result = '0;
    case (op_i)
      2'b10:   fast_result = '1;
      2'b11:   fast_result = operand_a_i;
      default: fast_result = '0;
    endcase
  end
`else
  assign fast_zero   = 1'b0;
  assign fast_result = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op_i;
            opd_q     <= op_i[1] ? operand_b_i : operand_a_i;
            lo_q      <= op_i[1] ? operand_a_i : operand_b_i;
            hi_q      <= '0;
            cnt_q     <= CNT_W'(DATA_W);
            rd_addr_o <= rd_addr_i;
            if (fast_zero) begin
              result_o <= fast_result;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q[1]) begin
              hi_q <= div_ge ? (div_shift[DATA_W-1:0] - opd_q) : div_shift[DATA_W-1:0];
              lo_q <= {lo_q[DATA_W-2:0], div_ge};
            end else begin
              hi_q <= mul_sum[DATA_W:1];
              lo_q <= {mul_sum[0], lo_q[DATA_W-1:1]};
            end
          end else begin
            // MULHU and REMU both live in hi_q; MUL and DIVU in lo_q.
            result_o <= op_q[0] ? hi_q : lo_q;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign write_en_o = done_o;

endmodule

// File: tb/tb_mul_div_unit_mod.sv
// Scoreboard bench for mul_div_unit_mod: randomized and directed ops against a plain-arithmetic model.
module tb_mul_div_unit_mod;
  localparam int DW = 34;
  localparam int AW = 5;
  localparam int FULL_LAT = DW + 1;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [1:0]    op_i;
  logic [DW-1:0] operand_a_i;
  logic [DW-1:0] operand_b_i;
  logic [AW-1:0] rd_addr_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;
  logic [AW-1:0] rd_addr_o;
  logic          write_en_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] res;
    logic [AW-1:0] rd;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  mul_div_unit_mod #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .write_en_o(write_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_model(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      2'd0:    return p[DW-1:0];
      2'd1:    return p[2*DW-1:DW];
      2'd2:    return (b == 0) ? {DW{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (op[1] ? (b == 0) : (a == 0 || b == 0)) return 0;
`endif
    return FULL_LAT;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] rd);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_idle_timeout", {67'b0, busy_o}, 68'd0);
    start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; rd_addr_i = rd;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    operand_a_i = {$urandom_range(3, 0), $urandom};
    operand_b_i = {$urandom_range(3, 0), $urandom};
    rd_addr_i   = AW'($urandom_range(31, 0));
    op_i        = 2'($urandom_range(3, 0));
    e.res = ref_model(op, a, b);
    e.rd  = rd;
    e.cyc = cyc + ref_lat(op, a, b);
    sb.push_back(e);
    chk("busy_after_accept", {67'b0, busy_o}, 68'd1);
  endtask

  function automatic logic [DW-1:0] rand_opnd();
    case ($urandom_range(9, 0))
      0:       return '0;
      1:       return {DW{1'b1}};
      2:       return DW'($urandom_range(15, 1));
      default: return {$urandom_range(3, 0), $urandom};
    endcase
  endfunction

  // Monitor: every write-back request is matched against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("we_eq_done", {67'b0, write_en_o}, {67'b0, done_o});
        if (done_o) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", {34'b0, result_o}, 68'd0);
            chk("unexpected_done_flag", {67'b0, done_o}, 68'd0);
          end else begin
            e = sb.pop_front();
            chk("result", {34'b0, result_o}, {34'b0, e.res});
            chk("rd_addr", {63'b0, rd_addr_o}, {63'b0, e.rd});
            chk("latency", 68'(cyc), 68'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0; start_i = 1'b0; op_i = '0;
    operand_a_i = '0; operand_b_i = '0; rd_addr_i = '0;
    #1;
    chk("rst_busy", {67'b0, busy_o}, 68'd0);
    chk("rst_done", {67'b0, done_o}, 68'd0);
    chk("rst_we", {67'b0, write_en_o}, 68'd0);
    chk("rst_result", {34'b0, result_o}, 68'd0);
    #1 rst_n = 1'b1;

    issue(2'd0, 34'd7, 34'd6, 5'd3);
    issue(2'd1, 34'h2_0000_0000, 34'd4, 5'd4);
    issue(2'd0, 34'h2_0000_0000, 34'd4, 5'd5);
    issue(2'd2, 34'd100, 34'd7, 5'd31);
    issue(2'd3, 34'd100, 34'd7, 5'd31);
    issue(2'd2, 34'h3_FFFF_FFFF, 34'd1, 5'd0);
    issue(2'd2, 34'd5, 34'd0, 5'd6);
    issue(2'd3, 34'd5, 34'd0, 5'd7);
    issue(2'd0, 34'd0, 34'h1_2345_6789, 5'd8);
    issue(2'd1, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 5'd9);

    // A second start while busy must be dropped; only 3*3 is expected.
    issue(2'd0, 34'd3, 34'd3, 5'd10);
    repeat (5) @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; operand_a_i = 34'd9; operand_b_i = 34'd9; rd_addr_i = 5'd11;
    repeat (10) @(negedge clk);
    start_i = 1'b0;

    // Reset mid-calculation aborts with no write-back.
    issue(2'd0, 34'd123, 34'd456, 5'd12);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {67'b0, busy_o}, 68'd0);
    chk("abort_done", {67'b0, done_o}, 68'd0);
    chk("abort_we", {67'b0, write_en_o}, 68'd0);
    chk("abort_result", {34'b0, result_o}, 68'd0);
    chk("abort_rd", {63'b0, rd_addr_o}, 68'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int op = 0; op < 4; op++) begin
      for (int n = 0; n < 150; n++) begin
        issue(2'(op), rand_opnd(), rand_opnd(), AW'($urandom_range(31, 0)));
      end
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 68'(sb.size()), 68'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
